// File: rtl/appr_mult_param.sv
// appr_mult_param: sequential approximate unsigned multiplier behind a start/done handshake.
// Each operand is normalised by leading-one shifting, truncated to its top KEEP bits,
// multiplied by shift-add, and the product is rescaled to 2*WIDTH bits. Latency is fixed
// at WIDTH busy cycles followed by one DONE cycle.
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   start      in   request, sampled only in IDLE or DONE
//   a, b       in   WIDTH-bit unsigned operands, latched on the accepting edge
//   busy       out  high while normalising or multiplying
//   done       out  one-cycle pulse, high while in DONE
//   product    out  2*WIDTH-bit approximate product, held until the next DONE
//   truncated  out  nonzero operand bits were discarded; valid with product
module appr_mult_param #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned KEEP  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product,
    output logic               truncated
);

    localparam int unsigned NW = WIDTH - KEEP;          // normalisation cycles
    localparam int unsigned CW = $clog2(WIDTH + 1);     // counter / shift-count width
    localparam int unsigned SW = CW + 1;                // rescale shift width
    localparam int unsigned PW = 2 * WIDTH;             // product width
    localparam int unsigned AW = 2 * KEEP;              // accumulator width
    // Bits below the retained window; zero when KEEP == WIDTH.
    localparam logic [WIDTH-1:0] LOW_MASK = {WIDTH{1'b1}} >> KEEP;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_MULT = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // With no bits to discard there is nothing to normalise.
    localparam state_t FIRST = (NW == 0) ? S_MULT : S_NORM;

    state_t          r_state;
    logic [WIDTH-1:0] r_xa;
    logic [WIDTH-1:0] r_xb;
    logic [CW-1:0]    r_sa;
    logic [CW-1:0]    r_sb;
    logic [CW-1:0]    r_cnt;
    logic [AW-1:0]    r_acc;

    logic [KEEP-1:0]  w_ta;
    logic [KEEP-1:0]  w_tb;
    logic [KEEP-1:0]  w_tb_sh;
    logic [AW-1:0]    w_pp;
    logic [AW-1:0]    w_acc_nxt;
    logic [CW-1:0]    w_ea;
    logic [CW-1:0]    w_eb;
    logic [SW-1:0]    w_shamt;
    logic [PW-1:0]    w_prod;
    logic             w_drop_a;
    logic             w_drop_b;
    logic             w_nz;
    logic             w_last_norm;
    logic             w_last_mult;

    // Truncated operands, shift-add step and rescale of the completed accumulator.
    always_comb begin
        w_ta        = r_xa[WIDTH-1 -: KEEP];
        w_tb        = r_xb[WIDTH-1 -: KEEP];
        w_tb_sh     = w_tb >> r_cnt;
        w_pp        = w_tb_sh[0] ? (AW'(w_ta) << r_cnt) : '0;
        w_acc_nxt   = r_acc + w_pp;
        w_ea        = CW'(NW) - r_sa;
        w_eb        = CW'(NW) - r_sb;
        w_shamt     = SW'(w_ea) + SW'(w_eb);
        w_prod      = PW'(w_acc_nxt) << w_shamt;
        w_drop_a    = |(r_xa & LOW_MASK);
        w_drop_b    = |(r_xb & LOW_MASK);
        w_nz        = (r_xa != '0) && (r_xb != '0);
        w_last_norm = (r_cnt == CW'(NW - 1));
        w_last_mult = (r_cnt == CW'(KEEP - 1));
    end

    // Control FSM with datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_xa      <= '0;
            r_xb      <= '0;
            r_sa      <= '0;
            r_sb      <= '0;
            r_cnt     <= '0;
            r_acc     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
            truncated <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        r_xa    <= a;
                        r_xb    <= b;
                        r_sa    <= '0;
                        r_sb    <= '0;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        busy    <= 1'b1;
                        r_state <= FIRST;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_NORM: begin
                    // Shift each operand up until its MSB is set or the discard budget is used.
                    if (!r_xa[WIDTH-1] && (r_sa < CW'(NW))) begin
                        r_xa <= r_xa << 1;
                        r_sa <= r_sa + CW'(1);
                    end
                    if (!r_xb[WIDTH-1] && (r_sb < CW'(NW))) begin
                        r_xb <= r_xb << 1;
                        r_sb <= r_sb + CW'(1);
                    end
                    if (w_last_norm) begin
                        r_cnt   <= '0;
                        r_state <= S_MULT;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_MULT: begin
                    r_acc <= w_acc_nxt;
                    if (w_last_mult) begin
                        r_cnt     <= '0;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        product   <= w_prod;
                        truncated <= (w_drop_a | w_drop_b) & w_nz;
                        r_state   <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_appr_mult_param.sv
// Directed bench for appr_mult_param at WIDTH=16, KEEP=8.
module tb_appr_mult_param;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a;
    logic [15:0] b;
    logic        busy;
    logic        done;
    logic [31:0] product;
    logic        truncated;

    int n_checks;
    int n_err;

    appr_mult_param #(.WIDTH(16), .KEEP(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .product   (product),
        .truncated (truncated)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present operands with start for one edge; returns just after the accepting edge.
    task automatic start_op(input logic [15:0] ia, input logic [15:0] ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = 16'hDEAD;
        b     = 16'hBEEF;
    endtask

    // Counts edges until done (bounded) and the busy cycles seen on the way.
    task automatic wait_done(output int n, output int nbusy);
        n     = 0;
        nbusy = 0;
        while (!done && n < 40) begin
            if (busy) nbusy++;
            tick();
            n++;
        end
    endtask

    task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                          input logic [31:0] exp_p, input logic exp_t);
        int n;
        int nb;
        start_op(ia, ib);
        wait_done(n, nb);
        check({tag, "_latency"}, 64'(n), 64'd16);
        check({tag, "_product"}, 64'(product), 64'(exp_p));
        check({tag, "_trunc"}, 64'(truncated), 64'(exp_t));
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int n;
        int nb;
        int ndone;
        n_checks = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        start    = 1'b0;
        a        = '0;
        b        = '0;

        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", 64'(product), 64'd0);
        check("rst_trunc", 64'(truncated), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 1: small operands, exact result; busy spans 16 cycles
        start_op(16'd200, 16'd100);
        check("t1_busy_after_accept", 64'(busy), 64'd1);
        wait_done(n, nb);
        check("t1_latency", 64'(n), 64'd16);
        check("t1_busy_cycles", 64'(nb), 64'd16);
        check("t1_busy_in_done", 64'(busy), 64'd0);
        check("t1_product", 64'(product), 64'd20000);
        check("t1_trunc", 64'(truncated), 64'd0);
        tick();
        check("t1_done_pulse", 64'(done), 64'd0);

        // 2: full-scale operands
        run_op("t2", 16'hFFFF, 16'hFFFF, 32'hFE01_0000, 1'b1);

        // 3: partial normalisation, low bit of A dropped
        run_op("t3", 16'h0123, 16'd3, 32'd870, 1'b1);

        // Boundary: leading ones exactly at the window, nothing dropped
        run_op("tb_pow2", 16'h8000, 16'h8000, 32'h4000_0000, 1'b0);
        run_op("tb_exact", 16'h0100, 16'h00FF, 32'd65280, 1'b0);

        // 4: zero operand; start held through busy must not queue a second op
        a     = 16'd0;
        b     = 16'hFFFF;
        start = 1'b1;
        tick();
        a     = 16'h1234;
        b     = 16'h5678;
        for (int i = 0; i < 10; i++) tick();
        start = 1'b0;
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    check("t4_product", 64'(product), 64'd0);
                    check("t4_trunc", 64'(truncated), 64'd0);
                end
            end
            tick();
        end
        check("t4_done_count", 64'(ndone), 64'd1);

        // 5: restart in the DONE cycle; previous product held until the next done
        start_op(16'd200, 16'd100);
        wait_done(n, nb);
        check("t5a_product", 64'(product), 64'd20000);
        start_op(16'd7, 16'd9);
        check("t5_busy_restart", 64'(busy), 64'd1);
        check("t5_done_low", 64'(done), 64'd0);
        check("t5_held_product", 64'(product), 64'd20000);
        for (int i = 0; i < 8; i++) tick();
        check("t5_held_mid", 64'(product), 64'd20000);
        wait_done(n, nb);
        check("t5_latency", 64'(n), 64'd8);
        check("t5_product", 64'(product), 64'd63);
        check("t5_trunc", 64'(truncated), 64'd0);
        tick();

        // 6: reset mid-operation
        start_op(16'hFFFF, 16'hFFFF);
        for (int i = 0; i < 4; i++) tick();
        rst_n = 1'b0;
        #1;
        check("t6_busy", 64'(busy), 64'd0);
        check("t6_done", 64'(done), 64'd0);
        check("t6_product", 64'(product), 64'd0);
        check("t6_trunc", 64'(truncated), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 25; i++) begin
            if (done || busy) ndone++;
            tick();
        end
        check("t6_no_done", 64'(ndone), 64'd0);
        run_op("t6_after", 16'd200, 16'd100, 32'd20000, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
